// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and defaults for the CPU control blocks
package cpu_ctrl_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_IMEM = 1'b1
  } redirect_state_t;

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - free-running event counter, wraps modulo 2^CNT_W
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             INC,
  output logic [CNT_W-1:0] COUNT
);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      COUNT <= '0;
    end else if (INC) begin
      COUNT <= COUNT + 1'b1;
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - PC redirect and pipeline flush sequencer for taken EX branches
module branch_redirect_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EX_VALID,
  input  logic             PC_SEL,
  input  logic [XLEN-1:0]  BRANCH_TARGET,
  input  logic             STALL,
  input  logic             IMEM_BUSY,
  output logic             PC_LOAD,
  output logic [XLEN-1:0]  PC_TARGET,
  output logic             FLUSH_IFID,
  output logic             FLUSH_IDEX,
  output logic             HOLD_FETCH,
  output logic             BUSY,
  output logic [CNT_W-1:0] TAKEN_COUNT,
  output logic [CNT_W-1:0] WAIT_COUNT
);

  redirect_state_t state, state_n;
  logic            fired;
  logic [XLEN-1:0] tgt_q;
  logic            evt;
  logic            accept;
  logic            latch_tgt;
  logic            taken_inc;
  logic            wait_inc;

  // fired suppresses a second redirect while the same EX instruction is stalled
  assign evt = EX_VALID & PC_SEL & ~fired;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      fired <= 1'b0;
      tgt_q <= '0;
    end else begin
      state <= state_n;
      if (!STALL) begin
        fired <= 1'b0;
      end else if (accept) begin
        fired <= 1'b1;
      end
      if (latch_tgt) begin
        tgt_q <= BRANCH_TARGET;
      end
    end
  end

  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    latch_tgt  = 1'b0;
    taken_inc  = 1'b0;
    wait_inc   = 1'b0;
    PC_LOAD    = 1'b0;
    PC_TARGET  = BRANCH_TARGET;
    FLUSH_IFID = 1'b0;
    FLUSH_IDEX = 1'b0;
    HOLD_FETCH = 1'b0;
    BUSY       = 1'b0;
    unique case (state)
      IDLE: begin
        if (evt) begin
          accept     = 1'b1;
          taken_inc  = 1'b1;
          FLUSH_IFID = 1'b1;
          FLUSH_IDEX = 1'b1;
          if (IMEM_BUSY) begin
            latch_tgt  = 1'b1;
            HOLD_FETCH = 1'b1;
            state_n    = WAIT_IMEM;
          end else begin
            PC_LOAD = 1'b1;
          end
        end
      end
      WAIT_IMEM: begin
        FLUSH_IFID = 1'b1;
        HOLD_FETCH = 1'b1;
        BUSY       = 1'b1;
        PC_TARGET  = tgt_q;
        if (IMEM_BUSY) begin
          wait_inc = 1'b1;
        end else begin
          PC_LOAD = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  perf_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (taken_inc),
    .COUNT (TAKEN_COUNT)
  );

  perf_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (wait_inc),
    .COUNT (WAIT_COUNT)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - directed self-checking bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid;
  logic             pc_sel;
  logic [XLEN-1:0]  branch_target;
  logic             stall;
  logic             imem_busy;
  logic             pc_load;
  logic [XLEN-1:0]  pc_target;
  logic             flush_ifid;
  logic             flush_idex;
  logic             hold_fetch;
  logic             busy;
  logic [CNT_W-1:0] taken_count;
  logic [CNT_W-1:0] wait_count;

  int checks = 0;
  int errors = 0;
  int loads;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .CLK           (clk),
    .RESET         (rst),
    .EX_VALID      (ex_valid),
    .PC_SEL        (pc_sel),
    .BRANCH_TARGET (branch_target),
    .STALL         (stall),
    .IMEM_BUSY     (imem_busy),
    .PC_LOAD       (pc_load),
    .PC_TARGET     (pc_target),
    .FLUSH_IFID    (flush_ifid),
    .FLUSH_IDEX    (flush_idex),
    .HOLD_FETCH    (hold_fetch),
    .BUSY          (busy),
    .TAKEN_COUNT   (taken_count),
    .WAIT_COUNT    (wait_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // strobe order: PC_LOAD, FLUSH_IFID, FLUSH_IDEX, HOLD_FETCH, BUSY
  task automatic chk_strobes(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, pc_load, flush_ifid, flush_idex, hold_fetch, busy}, {27'd0, exp});
  endtask

  task automatic drive(input logic v, input logic s, input logic [XLEN-1:0] t,
                       input logic st, input logic ib);
    @(negedge clk);
    ex_valid      = v;
    pc_sel        = s;
    branch_target = t;
    stall         = st;
    imem_busy     = ib;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; pc_sel = 1'b0; branch_target = 32'h55; stall = 1'b0; imem_busy = 1'b0;
    #12;
    chk_strobes("reset_strobes", 5'b00000);
    chk("reset_pc_target", pc_target, 32'h55);
    chk("reset_taken", {28'd0, taken_count}, 32'd0);
    chk("reset_wait", {28'd0, wait_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    drive(1'b0, 1'b1, 32'h0000_0900, 1'b0, 1'b0);
    chk_strobes("pcsel_no_valid", 5'b00000);

    drive(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    chk_strobes("single_strobes", 5'b11100);
    chk("single_pc_target", pc_target, 32'h100);
    drive(1'b0, 1'b0, 32'h0000_0104, 1'b0, 1'b0);
    chk_strobes("single_after", 5'b00000);
    chk("single_taken", {28'd0, taken_count}, 32'd1);

    drive(1'b1, 1'b1, 32'h0000_2000, 1'b0, 1'b1);
    chk_strobes("busy_c0", 5'b01110);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b0, 32'hdead_beef, 1'b0, 1'b1);
      chk_strobes($sformatf("busy_c%0d", i), 5'b01011);
      chk($sformatf("busy_tgt_c%0d", i), pc_target, 32'h2000);
    end
    drive(1'b0, 1'b0, 32'hdead_beef, 1'b0, 1'b0);
    chk_strobes("busy_c4", 5'b11011);
    chk("busy_c4_target", pc_target, 32'h2000);
    drive(1'b0, 1'b0, 32'h0000_0044, 1'b0, 1'b0);
    chk_strobes("busy_after", 5'b00000);
    chk("busy_after_target", pc_target, 32'h44);
    chk("busy_wait_count", {28'd0, wait_count}, 32'd3);
    chk("busy_taken", {28'd0, taken_count}, 32'd2);

    loads = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 32'h0000_0300, (i < 4), 1'b0);
      loads += int'(pc_load);
      if (i > 0) chk_strobes($sformatf("stall_c%0d", i), 5'b00000);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("stall_loads", loads, 32'd1);
    chk("stall_taken", {28'd0, taken_count}, 32'd3);

    drive(1'b1, 1'b1, 32'h0000_0400, 1'b0, 1'b1);
    chk_strobes("rstw_c0", 5'b01110);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("rstw_busy1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_strobes("rstw_in_reset", 5'b00000);
    chk("rstw_taken_clr", {28'd0, taken_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    imem_busy = 1'b0;
    #1;
    chk_strobes("rstw_release", 5'b00000);
    chk("rstw_wait_clr", {28'd0, wait_count}, 32'd0);

    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
      chk($sformatf("wrap_load_%0d", i), {31'd0, pc_load}, 32'd1);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk($sformatf("wrap_taken_%0d", i), {28'd0, taken_count}, 32'(i % 16));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
